// File: rtl/ssd_scan_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : ssd_scan_ctrl
// Purpose  : Seven-segment scan controller with inter-digit blanking, leading-
//            zero suppression and frame-aligned load/ready word updates.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module ssd_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000,
  parameter int BLANK_CYC  = 16,
  localparam int IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int MAXC      = (DIV > BLANK_CYC) ? DIV : BLANK_CYC,
  localparam int CW        = (MAXC > 1) ? $clog2(MAXC) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic                    load,
  output logic                    ready,
  input  logic                    lz_en,
  output logic [3:0]              digit_val,
  output logic                    seg_blank,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IW-1:0]           digit_idx
);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  state_t                  state, state_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_nxt, pending;
  logic                    pending_valid;
  logic                    commit;
  logic [3:0]              nibble;
  logic                    upper_zero;
  logic                    lz_hit;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt + 1'b1;
    commit    = 1'b0;
    case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nxt = ST_SHOW;
          cnt_nxt   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt == DIV_LAST) begin
          state_nxt = ST_BLANK;
          cnt_nxt   = '0;
          if (idx == IDX_LAST) begin
            idx_nxt = '0;
            commit  = pending_valid;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_BLANK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the post-edge state, so decode against next values.
  always_comb begin
    shadow_nxt = commit ? pending : shadow;
    nibble     = shadow_nxt[4*idx_nxt +: 4];
    upper_zero = 1'b1;
    lz_hit     = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero & (shadow_nxt[4*k +: 4] == 4'd0);
      if (idx_nxt == IW'(k)) begin
        lz_hit = upper_zero;
      end
    end
    lz_hit = lz_hit & lz_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_BLANK;
      idx           <= '0;
      cnt           <= '0;
      shadow        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      ready         <= 1'b1;
      an            <= '1;
      seg_blank     <= 1'b1;
      digit_val     <= 4'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      if (commit) begin
        shadow        <= pending;
        pending_valid <= 1'b0;
        ready         <= 1'b1;
      end else if (load && ready) begin
        pending       <= val_in;
        pending_valid <= 1'b1;
        ready         <= 1'b0;
      end
      if (state_nxt == ST_SHOW) begin
        digit_val <= nibble;
        if (lz_hit) begin
          an        <= '1;
          seg_blank <= 1'b1;
        end else begin
          an        <= ~(NUM_DIGITS'(1) << idx_nxt);
          seg_blank <= 1'b0;
        end
      end else begin
        an        <= '1;
        seg_blank <= 1'b1;
      end
    end
  end

  assign digit_idx = idx;

endmodule
`default_nettype wire
